// File: rtl/prbs_pkg.sv
// Shared PRBS-23 (x^23+x^18+1) definitions for the 12-bit-per-word pattern generator and checker.
package prbs_pkg;

    localparam int unsigned PRBS23_TAP_A = 17;
    localparam int unsigned PRBS23_TAP_B = 22;
    localparam int unsigned PRBS_WORD_W  = 12;

    typedef enum logic [1:0] {
        SEED0,
        SEED1,
        HUNT,
        LOCK
    } prbs_chk_state_e;

    // Bit 23 of the history is never a tap, so only 23 bits carry state.
    function automatic logic [11:0] prbs23_next(input logic [11:0] prev, input logic [11:0] cur);
        logic [23:0] tmp;
        tmp = {prev, cur};
        for (int i = 0; i < 12; i++) begin
            tmp = {tmp[22:0], tmp[PRBS23_TAP_A] ^ tmp[PRBS23_TAP_B]};
        end
        return tmp[11:0];
    endfunction

endpackage

// File: rtl/popcnt12.sv
// Combinational population count of a 12-bit word.
module popcnt12 (
    input  logic [11:0] din_i,
    output logic [3:0]  cnt_o
);

    always_comb begin
        cnt_o = 4'd0;
        for (int i = 0; i < 12; i++) begin
            cnt_o = cnt_o + {3'b000, din_i[i]};
        end
    end

endmodule

// File: rtl/prbs23_checker.sv
// Receive-side PRBS-23 word checker: self-seeds from the stream, hunts for lock, then flywheels
// the prediction and counts mismatching words.
module prbs23_checker
    import prbs_pkg::*;
#(
    parameter int unsigned LOCK_CNT   = 16,
    parameter int unsigned UNLOCK_CNT = 4,
    parameter int unsigned CNT_W      = 32
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [11:0]      DIN,
    input  logic             DVALID,
    input  logic             CLR,
    output logic             LOCKED,
    output logic             ERR,
    output logic [3:0]       ERRBITS,
    output logic [CNT_W-1:0] ERRCNT,
    output logic [CNT_W-1:0] WORDCNT
);

    localparam int unsigned MW = $clog2(LOCK_CNT + 1);
    localparam int unsigned RW = $clog2(UNLOCK_CNT + 1);

    prbs_chk_state_e  state_q, state_d;
    logic [11:0]      prev_q, prev_d;
    logic [11:0]      cur_q, cur_d;
    logic [MW-1:0]    match_q, match_d;
    logic [RW-1:0]    run_q, run_d;
    logic             locked_q, locked_d;
    logic             err_q, err_d;
    logic [3:0]       errbits_q, errbits_d;
    logic [CNT_W-1:0] errcnt_q, errcnt_d;
    logic [CNT_W-1:0] wordcnt_q, wordcnt_d;

    logic [11:0] exp_word;
    logic [11:0] diff;
    logic [3:0]  diff_bits;
    logic        mismatch;
    logic        hist_nz;
    logic        err_evt;
    logic        word_evt;

    assign exp_word = prbs23_next(prev_q, cur_q);
    assign diff     = DIN ^ exp_word;
    assign mismatch = |diff;
    // All-zero history predicts zero forever; it must never count toward lock.
    assign hist_nz  = |{prev_q, cur_q};

    popcnt12 u_popcnt (
        .din_i (diff),
        .cnt_o (diff_bits)
    );

    always_comb begin
        state_d   = state_q;
        prev_d    = prev_q;
        cur_d     = cur_q;
        match_d   = match_q;
        run_d     = run_q;
        locked_d  = locked_q;
        err_d     = 1'b0;
        errbits_d = 4'd0;
        err_evt   = 1'b0;
        word_evt  = 1'b0;
        if (DVALID) begin
            unique case (state_q)
                SEED0: begin
                    cur_d   = DIN;
                    state_d = SEED1;
                end
                SEED1: begin
                    prev_d  = cur_q;
                    cur_d   = DIN;
                    match_d = '0;
                    state_d = HUNT;
                end
                HUNT: begin
                    prev_d = cur_q;
                    cur_d  = DIN;
                    if (!mismatch && hist_nz) begin
                        if (match_q == MW'(LOCK_CNT - 1)) begin
                            state_d  = LOCK;
                            locked_d = 1'b1;
                            match_d  = '0;
                            run_d    = '0;
                        end else begin
                            match_d = match_q + MW'(1);
                        end
                    end else begin
                        match_d = '0;
                    end
                end
                LOCK: begin
                    // Flywheel on the prediction so a single bad word costs one error.
                    prev_d   = cur_q;
                    cur_d    = exp_word;
                    word_evt = 1'b1;
                    if (mismatch) begin
                        err_d     = 1'b1;
                        errbits_d = diff_bits;
                        err_evt   = 1'b1;
                        if (run_q == RW'(UNLOCK_CNT - 1)) begin
                            locked_d = 1'b0;
                            state_d  = SEED0;
                            run_d    = '0;
                        end else begin
                            run_d = run_q + RW'(1);
                        end
                    end else begin
                        run_d = '0;
                    end
                end
                default: state_d = SEED0;
            endcase
        end
    end

    // A clear coinciding with a counted event leaves the counter at one.
    always_comb begin
        if (CLR) begin
            errcnt_d = {{(CNT_W-1){1'b0}}, err_evt};
        end else if (err_evt && !(&errcnt_q)) begin
            errcnt_d = errcnt_q + CNT_W'(1);
        end else begin
            errcnt_d = errcnt_q;
        end

        if (CLR) begin
            wordcnt_d = {{(CNT_W-1){1'b0}}, word_evt};
        end else if (word_evt && !(&wordcnt_q)) begin
            wordcnt_d = wordcnt_q + CNT_W'(1);
        end else begin
            wordcnt_d = wordcnt_q;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q   <= SEED0;
            prev_q    <= 12'd0;
            cur_q     <= 12'd0;
            match_q   <= '0;
            run_q     <= '0;
            locked_q  <= 1'b0;
            err_q     <= 1'b0;
            errbits_q <= 4'd0;
            errcnt_q  <= '0;
            wordcnt_q <= '0;
        end else begin
            state_q   <= state_d;
            prev_q    <= prev_d;
            cur_q     <= cur_d;
            match_q   <= match_d;
            run_q     <= run_d;
            locked_q  <= locked_d;
            err_q     <= err_d;
            errbits_q <= errbits_d;
            errcnt_q  <= errcnt_d;
            wordcnt_q <= wordcnt_d;
        end
    end

    assign LOCKED  = locked_q;
    assign ERR     = err_q;
    assign ERRBITS = errbits_q;
    assign ERRCNT  = errcnt_q;
    assign WORDCNT = wordcnt_q;

endmodule

// File: tb/tb_prbs23_checker.sv
// Bench for prbs23_checker: table vectors, directed corner sequences and a randomized run against
// a word-level reference model driven by the x^23+x^18+1 bit recurrence.
module tb_prbs23_checker;

    logic        clk;
    logic        rst_n;
    logic [11:0] din;
    logic        dvalid;
    logic        clr;
    logic        locked, err;
    logic [3:0]  errbits;
    logic [31:0] errcnt, wordcnt;
    logic        locked4, err4;
    logic [3:0]  errbits4;
    logic [3:0]  errcnt4, wordcnt4;

    prbs23_checker #(.LOCK_CNT(16), .UNLOCK_CNT(4), .CNT_W(32)) dut (
        .CLK(clk), .RST_N(rst_n), .DIN(din), .DVALID(dvalid), .CLR(clr),
        .LOCKED(locked), .ERR(err), .ERRBITS(errbits), .ERRCNT(errcnt), .WORDCNT(wordcnt)
    );

    prbs23_checker #(.LOCK_CNT(16), .UNLOCK_CNT(4), .CNT_W(4)) dut4 (
        .CLK(clk), .RST_N(rst_n), .DIN(din), .DVALID(dvalid), .CLR(clr),
        .LOCKED(locked4), .ERR(err4), .ERRBITS(errbits4), .ERRCNT(errcnt4), .WORDCNT(wordcnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, want);
        end
    endtask

    // Next word of the sequence from the two preceding words, via s[k] = s[k-18] ^ s[k-23].
    function automatic logic [11:0] follow(input logic [11:0] w_prev, input logic [11:0] w_cur);
        bit          s[36];
        logic [11:0] r;
        for (int i = 0; i < 12; i++) begin
            s[i]      = w_prev[11-i];
            s[12 + i] = w_cur[11-i];
        end
        for (int k = 24; k < 36; k++) s[k] = s[k-18] ^ s[k-23];
        for (int i = 0; i < 12; i++) r[11-i] = s[24 + i];
        return r;
    endfunction

    logic [11:0] g_a = 12'h000;
    logic [11:0] g_b = 12'h001;

    task automatic gen_take(output logic [11:0] w);
        logic [11:0] nxt;
        w   = g_a;
        nxt = follow(g_a, g_b);
        g_a = g_b;
        g_b = nxt;
    endtask

    // Reference model state
    int          m_phase;  // 0 first seed, 1 second seed, 2 hunting, 3 locked
    logic [11:0] m_prev, m_cur;
    int          m_match, m_miss;
    longint      m_errcnt, m_wordcnt;
    bit          m_locked, m_err;
    int          m_errbits;

    task automatic model_reset();
        m_phase = 0; m_prev = '0; m_cur = '0; m_match = 0; m_miss = 0;
        m_errcnt = 0; m_wordcnt = 0; m_locked = 0; m_err = 0; m_errbits = 0;
    endtask

    task automatic model_step(input bit r, input bit v, input bit c, input logic [11:0] w);
        logic [11:0] e;
        bit          ev_err, ev_word;
        ev_err = 0; ev_word = 0;
        if (!r) begin
            model_reset();
            return;
        end
        m_err = 0; m_errbits = 0;
        if (v) begin
            e = follow(m_prev, m_cur);
            case (m_phase)
                0: begin m_cur = w; m_phase = 1; end
                1: begin m_prev = m_cur; m_cur = w; m_match = 0; m_phase = 2; end
                2: begin
                    if (w == e && {m_prev, m_cur} != 24'd0) m_match++;
                    else m_match = 0;
                    m_prev = m_cur; m_cur = w;
                    if (m_match == 16) begin m_phase = 3; m_locked = 1; m_miss = 0; end
                end
                default: begin
                    ev_word = 1;
                    if (w != e) begin
                        m_err = 1; m_errbits = $countones(w ^ e); ev_err = 1; m_miss++;
                    end else m_miss = 0;
                    m_prev = m_cur; m_cur = e;
                    if (m_miss == 4) begin m_locked = 0; m_phase = 0; m_miss = 0; end
                end
            endcase
        end
        if (c) begin
            m_errcnt = longint'(ev_err); m_wordcnt = longint'(ev_word);
        end else begin
            m_errcnt += longint'(ev_err); m_wordcnt += longint'(ev_word);
        end
    endtask

    task automatic step(input bit r, input bit v, input bit c, input logic [11:0] w);
        logic [3:0] e4, w4;
        rst_n = r; dvalid = v; clr = c; din = w;
        @(posedge clk);
        model_step(r, v, c, w);
        #1;
        e4 = (m_errcnt > 15) ? 4'hF : 4'(m_errcnt);
        w4 = (m_wordcnt > 15) ? 4'hF : 4'(m_wordcnt);
        check("model", {locked, err, errbits, errcnt, wordcnt, locked4, err4, errbits4, errcnt4, wordcnt4},
              {m_locked, m_err, 4'(m_errbits), 32'(m_errcnt), 32'(m_wordcnt),
               m_locked, m_err, 4'(m_errbits), e4, w4});
    endtask

    typedef struct {
        bit          rst_n, dvalid, clr, use_gen;
        logic [11:0] val;  // xor mask on the next generator word, or literal DIN
        bit          x_locked, x_err;
        int          x_errbits, x_errcnt, x_wordcnt;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input bit r, input bit v, input bit c, input bit g, input logic [11:0] val,
                       input bit xl, input bit xe, input int xb, input int xc, input int xw);
        vec_t t;
        t.rst_n = r; t.dvalid = v; t.clr = c; t.use_gen = g; t.val = val;
        t.x_locked = xl; t.x_err = xe; t.x_errbits = xb; t.x_errcnt = xc; t.x_wordcnt = xw;
        tbl.push_back(t);
    endtask

    logic [11:0] w;
    int          seen;
    int          burst;
    bit          rv, dv, cl;

    initial begin
        rst_n = 1'b0; dvalid = 1'b0; clr = 1'b0; din = '0;
        model_reset();

        // Reset, 2 seeds + 16 matching words, lock, one XOR 0x021 error, clear interplay.
        add(0, 0, 0, 0, 12'h000, 0, 0, 0, 0, 0);
        for (int i = 0; i < 18; i++) add(1, 1, 0, 1, 12'h000, (i == 17), 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) add(1, 1, 0, 1, 12'h000, 1, 0, 0, 0, i + 1);
        add(1, 0, 0, 0, 12'h000, 1, 0, 0, 0, 3);
        add(1, 1, 0, 1, 12'h021, 1, 1, 2, 1, 4);
        for (int i = 0; i < 3; i++) add(1, 1, 0, 1, 12'h000, 1, 0, 0, 1, 5 + i);
        add(1, 0, 1, 0, 12'h000, 1, 0, 0, 0, 0);
        add(1, 1, 1, 1, 12'h800, 1, 1, 1, 1, 1);
        add(1, 1, 0, 1, 12'h000, 1, 0, 0, 1, 2);

        foreach (tbl[i]) begin
            if (tbl[i].use_gen) begin
                gen_take(w);
                w = w ^ tbl[i].val;
            end else begin
                w = tbl[i].val;
            end
            step(tbl[i].rst_n, tbl[i].dvalid, tbl[i].clr, w);
            check($sformatf("vec%0d", i), {locked, err, errbits, errcnt, wordcnt},
                  {tbl[i].x_locked, tbl[i].x_err, 4'(tbl[i].x_errbits),
                   32'(tbl[i].x_errcnt), 32'(tbl[i].x_wordcnt)});
        end

        // Four consecutive corrupted words drop lock; clean stream relocks after 2+16 words.
        step(1, 0, 1, 12'h000);
        for (int i = 0; i < 4; i++) begin
            gen_take(w);
            step(1, 1, 0, w ^ 12'($urandom_range(1, 4095)));
            check("burst_err", {err, locked, errcnt}, {1'b1, (i < 3), 32'(i + 1)});
        end
        check("burst_wordcnt", wordcnt, 32'd4);
        for (int i = 0; i < 18; i++) begin
            gen_take(w);
            step(1, 1, 0, w);
            if (i == 16 || i == 17) check("relock", locked, (i == 17));
        end

        // Every third cycle idle while locked: no errors, only valid words counted.
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            if (i % 3 != 2) begin
                gen_take(w);
                step(1, 1, 0, w);
            end else begin
                step(1, 0, 0, 12'hABC);
            end
            seen += int'(err);
        end
        check("gap_err", seen, 0);
        check("gap_wordcnt", wordcnt, 32'd24);

        // Saturation of the 4-bit counters with errors spread out so lock is kept.
        step(1, 0, 1, 12'h000);
        for (int i = 0; i < 16; i++) begin
            gen_take(w);
            step(1, 1, 0, w ^ 12'h001);
            if (i >= 14) check("sat_errcnt4", errcnt4, 4'hF);
            gen_take(w);
            step(1, 1, 0, w);
        end
        check("sat_errcnt32", errcnt, 32'd16);
        check("sat_wordcnt4", {locked4, wordcnt4}, {1'b1, 4'hF});

        // Reset mid-lock clears every output.
        gen_take(w);
        step(0, 1, 0, w);
        check("rst_outputs", {locked, err, errbits, errcnt, wordcnt, errcnt4, wordcnt4}, '0);

        // Stuck-at-zero input must never lock.
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            step(1, 1, 0, 12'h000);
            seen += int'(locked);
        end
        check("zero_never_locks", {seen, errcnt, locked}, {32'd0, 32'd0, 1'b0});

        // Randomized stream: gaps, single-word hits, bursts, clears and occasional resets.
        burst = 0;
        for (int c = 0; c < 3000; c++) begin
            rv = ($urandom_range(0, 999) != 0);
            dv = ($urandom_range(0, 99) < 85);
            cl = ($urandom_range(0, 99) < 2);
            w  = 12'($urandom_range(0, 4095));
            if (dv) begin
                gen_take(w);
                if (burst > 0) begin
                    w = w ^ 12'($urandom_range(1, 4095));
                    burst--;
                end else if ($urandom_range(0, 99) < 3) begin
                    w = w ^ 12'($urandom_range(1, 4095));
                end else if ($urandom_range(0, 199) == 0) begin
                    burst = $urandom_range(4, 6);
                end
            end
            step(rv, dv, cl, w);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
